mult_arbiter: RTL and testbench

- Shares one iterative 8x8 shift-add multiplier between N_REQ requesters.
- Round-robin arbitration; per-requester valid/ready operand handshake; single response channel tagged with requester ID.
- Sits between the requesting blocks and the multiplier core, sequencing core start, iteration and result hand-back.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_core.sv | 60 ++++++
 rtl/mult_arbiter.sv | 113 +++++++++++
 tb/tb_mult_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter slice.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Modular increment used to walk the round-robin ring.
  function automatic logic [7:0] rr_next(input logic [7:0] ptr, input logic [7:0] n);
    if (ptr >= n - 8'd1) begin
      return 8'd0;
    end else begin
      return ptr + 8'd1;
    end
  endfunction

endpackage

// File: rtl/mult_core.sv
// Iterative unsigned shift-add multiplier: operands load on start, then exactly
// WIDTH add/shift steps. done is high during the cycle that ends in the last step.
module mult_core
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;

  // Operand load on start, then one shift-add step per edge while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= {2*WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {2*WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, x};
      mplier_q <= y;
      acc_q    <= {2*WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else if (busy_q) begin
      acc_q    <= acc_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
      // Flag the cycle whose closing edge performs the final step.
      done_q   <= (cnt_q == CW'(WIDTH - 2));
      busy_q   <= (cnt_q != CW'(WIDTH - 1));
    end else begin
      done_q   <= 1'b0;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign z    = acc_q;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one mult_core between N_REQ requesters, with a
// single ID-tagged response channel.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_x,
  input  logic [N_REQ*WIDTH-1:0]     req_y,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2*WIDTH-1:0]         rsp_z,
  output logic [$clog2(N_REQ)-1:0]   rsp_id
);

  localparam int ID_W = $clog2(N_REQ);

  arb_state_t         state_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    id_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;

  logic [ID_W-1:0]    scan_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic               grant_found_s;
  logic               take_s;
  logic               accept_s;
  logic [WIDTH-1:0]   core_x_s;
  logic [WIDTH-1:0]   core_y_s;
  logic               core_busy_s;
  logic               core_done_s;
  logic [2*WIDTH-1:0] core_z_s;

  // Round-robin search starting just after the last winner.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {ID_W{1'b0}};
    scan_s        = rr_ptr_q;
    take_s        = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_s        = ID_W'(rr_next(8'(scan_s), 8'(N_REQ)));
      take_s        = !grant_found_s && req_valid[scan_s];
      grant_idx_s   = take_s ? scan_s : grant_idx_s;
      grant_found_s = grant_found_s | take_s;
    end
  end

  assign accept_s  = (state_q == IDLE) && grant_found_s;
  assign req_ready = accept_s ? (N_REQ'(1) << grant_idx_s) : {N_REQ{1'b0}};
  assign core_x_s  = req_x[grant_idx_s*WIDTH +: WIDTH];
  assign core_y_s  = req_y[grant_idx_s*WIDTH +: WIDTH];

  // Arbitration FSM: grant, wait for the core, hold the response until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(N_REQ - 1);
      id_q        <= {ID_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= {ID_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_q  <= BUSY;
            rr_ptr_q <= grant_idx_s;
            id_q     <= grant_idx_s;
          end
        end
        BUSY: begin
          if (core_busy_s && core_done_s) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  mult_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (accept_s),
    .x     (core_x_s),
    .y     (core_y_s),
    .busy  (core_busy_s),
    .done  (core_done_s),
    .z     (core_z_s)
  );

  // The core accumulator holds its product until the next start.
  assign rsp_z     = core_z_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: stimulus pushes expected grants and
// responses, a negedge monitor pops and compares them.
module tb_mult_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [2*W-1:0] rsp_z;
  logic [1:0]    rsp_id;

  always #5 clk = ~clk;

  mult_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_id    (rsp_id)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] z;
  } rsp_t;

  rsp_t exp_rsp[$];
  int   exp_grant[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor state
  logic [N-1:0] mon_a;
  rsp_t         mon_e;
  int           acc_edge = 0;
  bit           in_flight = 1'b0;
  bit           noise = 1'b0;
  bit           prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      in_flight  = 1'b0;
      noise      = 1'b0;
      prev_valid = 1'b0;
    end else begin
      mon_a = req_valid & req_ready;
      if (mon_a != 4'b0) begin
        if (in_flight) chk("grant_while_busy", 32'(mon_a), 32'd0);
        if (exp_grant.size() == 0) chk("grant_unexpected", 32'(mon_a), 32'd0);
        else chk("grant_id", 32'(mon_a), 32'd1 << exp_grant.pop_front());
        acc_edge  = cyc + 1;
        in_flight = 1'b1;
        noise     = 1'b0;
      end else if (in_flight && req_ready != 4'b0) begin
        noise = 1'b1;
      end
      if (rsp_valid && !prev_valid) chk("latency", 32'(cyc - acc_edge), 32'(W));
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else if (rsp_ready) begin
          mon_e = exp_rsp.pop_front();
          chk("rsp_z", 32'(rsp_z), 32'(mon_e.z));
          chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
          chk("ready_quiet", 32'(noise), 32'd0);
          in_flight = 1'b0;
        end else begin
          chk("hold_z", 32'(rsp_z), 32'(exp_rsp[0].z));
          chk("hold_id", 32'(rsp_id), 32'(exp_rsp[0].id));
        end
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic set_op(input int id, input logic [7:0] x, input logic [7:0] y);
    req_x[id*W +: W] = x;
    req_y[id*W +: W] = y;
  endtask

  task automatic expect_op(input int id, input logic [15:0] z);
    exp_grant.push_back(id);
    exp_rsp.push_back('{id: 2'(id), z: z});
  endtask

  task automatic step_accept(output logic [N-1:0] a);
    @(negedge clk);
    a = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~a;
  endtask

  task automatic drain(input int budget, input string tag);
    int t = 0;
    while ((exp_rsp.size() != 0 || exp_grant.size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({"drain_", tag}, 32'(exp_rsp.size() + exp_grant.size()), 32'd0);
  endtask

  task automatic accept_one(input int id, input string tag);
    logic [N-1:0] a;
    int t = 0;
    while (req_valid[id] && t < 30) begin
      step_accept(a);
      t++;
    end
    chk({"accept_", tag}, 32'(req_valid[id]), 32'd0);
  endtask

  task automatic run_single(input int id, input logic [7:0] x, input logic [7:0] y,
                            input logic [15:0] z, input string tag);
    @(posedge clk);
    #1;
    expect_op(id, z);
    set_op(id, x, y);
    req_valid[id] = 1'b1;
    accept_one(id, tag);
    drain(40, tag);
  endtask

  int fz[10] = '{200, 231, 264, 299, 336, 375, 416, 459, 504, 551};

  initial begin
    int t;
    logic [N-1:0] a;
    bit reissued;
    int n0, n3;
    bit seen;

    rst = 1'b1;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_z", 32'(rsp_z), 32'd0);
    chk("reset_id", 32'(rsp_id), 32'd0);

    // Four simultaneous requesters; req 0 re-raises after its grant.
    @(posedge clk);
    #1;
    expect_op(0, 16'd1);
    expect_op(1, 16'd6);
    expect_op(2, 16'd25);
    expect_op(3, 16'd65025);
    expect_op(0, 16'd21);
    set_op(0, 8'd1, 8'd1);
    set_op(1, 8'd2, 8'd3);
    set_op(2, 8'd5, 8'd5);
    set_op(3, 8'd255, 8'd255);
    req_valid = 4'hF;
    reissued = 1'b0;
    t = 0;
    while ((req_valid != 4'b0 || !reissued) && t < 100) begin
      step_accept(a);
      if (a[0] && !reissued) begin
        set_op(0, 8'd3, 8'd7);
        req_valid[0] = 1'b1;
        reissued = 1'b1;
      end
      t++;
    end
    chk("fourway_accept", 32'(req_valid), 32'd0);
    drain(40, "fourway");

    run_single(0, 8'd5, 8'd5, 16'd25, "single");

    // Backpressure: response held 20 cycles with another requester waiting.
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    expect_op(2, 16'd42);
    set_op(2, 8'd6, 8'd7);
    req_valid[2] = 1'b1;
    accept_one(2, "bp");
    t = 0;
    while (!rsp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    expect_op(1, 16'd81);
    set_op(1, 8'd9, 8'd9);
    req_valid[1] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'd2);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    drain(40, "bp");

    run_single(3, 8'd0, 8'd200, 16'd0, "zero");
    run_single(0, 8'd255, 8'd1, 16'd255, "max1");
    run_single(1, 8'd128, 8'd2, 16'd256, "shift");

    // Reset during step 4 of 7*9: no response, outputs back to reset values.
    @(posedge clk);
    #1;
    exp_grant.push_back(1);
    set_op(1, 8'd7, 8'd9);
    req_valid[1] = 1'b1;
    accept_one(1, "rstop");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 32'(req_ready), 32'd0);
    chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_z", 32'(rsp_z), 32'd0);
    chk("rst_mid_id", 32'(rsp_id), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    chk("rst_no_rsp", 32'(seen), 32'd0);

    // Fairness: req 0 and req 3 persistently valid for 10 operations.
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) expect_op((k % 2 == 0) ? 0 : 3, 16'(fz[k]));
    set_op(0, 8'd10, 8'd20);
    set_op(3, 8'd11, 8'd21);
    req_valid = 4'b1001;
    n0 = 2;
    n3 = 3;
    t = 0;
    while (req_valid != 4'b0 && t < 200) begin
      step_accept(a);
      if (a[0] && n0 < 10) begin
        set_op(0, 8'(10 + n0), 8'(20 + n0));
        req_valid[0] = 1'b1;
        n0 += 2;
      end
      if (a[3] && n3 < 10) begin
        set_op(3, 8'(10 + n3), 8'(20 + n3));
        req_valid[3] = 1'b1;
        n3 += 2;
      end
      t++;
    end
    chk("fair_accept", 32'(req_valid), 32'd0);
    drain(40, "fair");

    run_single(2, 8'd3, 8'd4, 16'd12, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", n_vec, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
